bram_fifo_ctrl: RTL and testbench

Streaming FIFO built around the team's `sync_dual_port_ram`, which has a 2-cycle registered read and no read enable. The block owns the RAM's write/read pointers and tracks in-flight reads with a valid pipe. A 4-entry prefetch buffer hides the read latency and presents a first-word-fall-through valid/ready interface. It sits between producer and consumer stages wherever a deep buffer is needed at full throughput.

---
 rtl/bram_fifo_ctrl.sv | 112 +++++++++++
 tb/tb_bram_fifo_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo_ctrl.sv
// Deep streaming FIFO: block RAM with a 2-cycle registered read, a valid pipe
// tracking in-flight reads, and a 4-entry prefetch buffer for first-word-fall-through output.
module bram_fifo_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH+1:0] count
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] RAM_FULL = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDRESS_WIDTH:0]   ram_count_q, ram_count_d;
  logic [1:0]               v_q, v_d;
  logic [2:0]               pf_count_q, pf_count_d;
  logic [1:0]               pf_wr_q, pf_wr_d;
  logic [1:0]               pf_rd_q, pf_rd_d;
  logic [DATA_WIDTH-1:0]    pf_mem_q [4];

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]    ram_rd1_q, ram_rd2_q;

  logic       wr_fire;
  logic       issue;
  logic       push;
  logic       pop;
  logic [2:0] credit_used;

  assign in_ready  = (ram_count_q != RAM_FULL);
  assign out_valid = (pf_count_q != 3'd0);
  assign out_data  = pf_mem_q[pf_rd_q];
  assign count     = {1'b0, ram_count_q}
                   + (ADDRESS_WIDTH+2)'(pf_count_q)
                   + (ADDRESS_WIDTH+2)'(v_q[0])
                   + (ADDRESS_WIDTH+2)'(v_q[1]);

  // Credit counts in-flight reads as already occupying prefetch slots,
  // so a captured word always has room.
  assign credit_used = pf_count_q + {2'b00, v_q[0]} + {2'b00, v_q[1]};

  always_comb begin
    wr_fire     = in_valid & in_ready;
    issue       = (ram_count_q != '0) && (credit_used < 3'd4);
    push        = v_q[1];
    pop         = out_valid & out_ready;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    pf_count_d  = pf_count_q;
    pf_wr_d     = pf_wr_q;
    pf_rd_d     = pf_rd_q;
    v_d         = {v_q[0], issue};

    if (wr_fire) wr_ptr_d = wr_ptr_q + ADDRESS_WIDTH'(1);
    if (issue)   rd_ptr_d = rd_ptr_q + ADDRESS_WIDTH'(1);
    if (push)    pf_wr_d  = pf_wr_q + 2'd1;
    if (pop)     pf_rd_d  = pf_rd_q + 2'd1;

    unique case ({wr_fire, issue})
      2'b10:   ram_count_d = ram_count_q + (ADDRESS_WIDTH+1)'(1);
      2'b01:   ram_count_d = ram_count_q - (ADDRESS_WIDTH+1)'(1);
      default: ram_count_d = ram_count_q;
    endcase

    unique case ({push, pop})
      2'b10:   pf_count_d = pf_count_q + 3'd1;
      2'b01:   pf_count_d = pf_count_q - 3'd1;
      default: pf_count_d = pf_count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      v_q         <= '0;
      pf_count_q  <= '0;
      pf_wr_q     <= '0;
      pf_rd_q     <= '0;
      for (int unsigned i = 0; i < 4; i++) pf_mem_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      v_q         <= v_d;
      pf_count_q  <= pf_count_d;
      pf_wr_q     <= pf_wr_d;
      pf_rd_q     <= pf_rd_d;
      if (push) pf_mem_q[pf_wr_q] <= ram_rd2_q;
    end
  end

  // Dual-port RAM: no read enable, read address always rd_ptr, two register stages on read.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= in_data;
    ram_rd1_q <= mem_q[rd_ptr_q];
    ram_rd2_q <= ram_rd1_q;
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl at ADDRESS_WIDTH=3 (capacity 12 words).
module tb_bram_fifo_ctrl;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [AW+1:0] count;

  int errors = 0;
  int checks = 0;

  bram_fifo_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          exp_in_ready;
    logic          exp_out_valid;
    logic          chk_data;
    logic [DW-1:0] exp_out_data;
    logic [AW+1:0] exp_count;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic iv, logic [DW-1:0] d, logic ordy, logic eir,
                              logic eov, logic cd, logic [DW-1:0] ed, logic [AW+1:0] ec);
    vec_t v;
    v.in_valid = iv;  v.in_data = d;  v.out_ready = ordy;
    v.exp_in_ready = eir;  v.exp_out_valid = eov;
    v.chk_data = cd;  v.exp_out_data = ed;  v.exp_count = ec;
    return v;
  endfunction

  function automatic logic [DW-1:0] stream_word(int i);
    return DW'(i * 7 + 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] sb[$];
    logic [DW-1:0] pd;
    logic          acc, pp;
    int            sent, got, first, last, max_cnt, cyc;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    #10 rst = 1'b0;
    tick();

    // Build state, then check reset takes effect without a clock edge.
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("pre_async_out_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_in_ready",  32'(in_ready),  32'd1);
    chk("async_count",     32'(count),     32'd0);
    chk("async_out_data",  32'(out_data),  32'd0);
    #2 rst = 1'b0;
    tick();

    // Single word latency.
    tbl.push_back(mk(1, 8'hA5, 1, 1, 0, 0, 8'h00, 5'd1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 5'd1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 5'd1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 1, 8'hA5, 5'd1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 5'd0));
    // Fill to capacity with consumer stalled.
    for (int k = 1; k <= 12; k++)
      tbl.push_back(mk(1, 8'(k), 0, k < 12, k >= 4, k >= 4, 8'h01, 5'(k)));
    tbl.push_back(mk(1, 8'hEE, 0, 0, 1, 1, 8'h01, 5'd12));
    // Drain.
    for (int k = 1; k <= 12; k++)
      tbl.push_back(mk(0, 8'h00, 1, k >= 2, k < 12, k < 12, 8'(k + 1), 5'(12 - k)));

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid  = tbl[i].in_valid;
      in_data   = tbl[i].in_data;
      out_ready = tbl[i].out_ready;
      tick();
      chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].exp_in_ready));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_out_valid));
      chk($sformatf("vec%0d_count", i),     32'(count),     32'(tbl[i].exp_count));
      if (tbl[i].chk_data)
        chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].exp_out_data));
    end
    in_valid = 1'b0; out_ready = 1'b0;

    // Streaming across many pointer wraps, both sides always ready.
    sent = 0; got = 0; first = -1; last = -1;
    for (cyc = 0; cyc < 300 && got < 100; cyc++) begin
      in_valid  = (sent < 100);
      in_data   = stream_word(sent);
      out_ready = 1'b1;
      acc = in_valid && in_ready;
      pp  = out_valid && out_ready;
      pd  = out_data;
      tick();
      if (acc) sent++;
      if (pp) begin
        chk($sformatf("stream_data%0d", got), 32'(pd), 32'(stream_word(got)));
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
    end
    chk("stream_words_out", 32'(got), 32'd100);
    chk("stream_first_pop", 32'(first), 32'd4);
    chk("stream_no_bubbles", 32'(last - first), 32'd99);
    in_valid = 1'b0;
    tick();
    chk("stream_empty_count", 32'(count), 32'd0);

    // Random backpressure with scoreboard.
    sent = 0; got = 0; max_cnt = 0;
    for (cyc = 0; cyc < 20000 && got < 2000; cyc++) begin
      in_valid  = (sent < 2000) && ($urandom_range(1, 0) == 1);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(1, 0) == 1);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      acc = in_valid && in_ready;
      pp  = out_valid && out_ready;
      pd  = out_data;
      if (acc) sb.push_back(in_data);
      tick();
      if (acc) sent++;
      if (pp) begin
        if (sb.size() == 0) begin
          chk("rand_unexpected_pop", 32'(pd), 32'hFFFF_FFFF);
        end else begin
          if (pd !== sb[0]) chk($sformatf("rand_data%0d", got), 32'(pd), 32'(sb[0]));
          void'(sb.pop_front());
        end
        got++;
      end
    end
    chk("rand_words_out", 32'(got), 32'd2000);
    chk("rand_sb_empty", 32'(sb.size()), 32'd0);
    chk("rand_max_count_le12", 32'(max_cnt <= 12), 32'd1);
    in_valid = 1'b0; out_ready = 1'b0;

    // Reset mid-operation with reads in flight.
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 8'(8'h50 + k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("midrst_pre_count", 32'(count), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    #2 rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("midrst_idle%0d_out_valid", k), 32'(out_valid), 32'd0);
    end
    in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("midrst_acc_count", 32'(count), 32'd1);
    tick();
    chk("midrst_e1_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("midrst_e2_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("midrst_e3_out_valid", 32'(out_valid), 32'd1);
    chk("midrst_e3_out_data",  32'(out_data),  32'h77);
    tick();
    chk("midrst_pop_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_pop_count",     32'(count),     32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
